// File: rtl/rx_acquire_pkg.sv
// rx_acquire_pkg: shared definitions for the rx acquisition slice.
//   - default widths/depth for rx_acquire
//   - FSM state enum (IDLE, ACQ)
//   - FIFO entry struct {last, data[, tstamp]}
//   - eff_decim(): maps a decimation request of 0 to 1
// Optional macro RX_ACQ_TIMESTAMP_EN adds a 32-bit timestamp field to the entry.
package rx_acquire_pkg;

    localparam int unsigned DATA_W_DEF     = 16;
    localparam int unsigned ACC_W_DEF      = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 16;
    localparam int unsigned TSTAMP_W       = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACQ  = 1'b1
    } acq_state_e;

    typedef struct packed {
        logic                 last;
        logic [ACC_W_DEF-1:0] data;
`ifdef RX_ACQ_TIMESTAMP_EN
        logic [TSTAMP_W-1:0]  tstamp;
`endif
    } fifo_entry_t;

    function automatic logic [15:0] eff_decim(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/rx_acquire_if.sv
// rx_acquire_if: decimated output stream (valid/ready).
//   out_data  : signed decimated sum
//   out_valid : out_data/out_last valid
//   out_ready : consumer accepts when out_valid && out_ready
//   out_last  : final word of an rx window
//   out_tstamp: word timestamp (only with RX_ACQ_TIMESTAMP_EN)
// master = producer (rx_acquire), slave = consumer.
interface rx_acquire_if import rx_acquire_pkg::*; #(
    parameter int unsigned ACC_W = ACC_W_DEF
) ();
    logic [ACC_W-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
`ifdef RX_ACQ_TIMESTAMP_EN
    logic [TSTAMP_W-1:0] out_tstamp;
`endif

    modport master (
        input  out_ready,
        output out_data, out_valid, out_last
`ifdef RX_ACQ_TIMESTAMP_EN
        , output out_tstamp
`endif
    );

    modport slave (
        output out_ready,
        input  out_data, out_valid, out_last
`ifdef RX_ACQ_TIMESTAMP_EN
        , input out_tstamp
`endif
    );
endinterface

// File: rtl/rx_acq_fifo.sv
// rx_acq_fifo: synchronous show-ahead FIFO with up to two pushes per cycle.
//   clk, rst        : clock, async active-high reset (pointers/count only)
//   push0_i/din0_i  : first write
//   push1_i/din1_i  : second write, only used together with push0_i
//   pop_i           : consume head (ignored when empty)
//   dout_o          : head entry (show-ahead)
//   full_o, empty_o : occupancy flags
//   free2_o         : at least two free entries
// Callers must not push beyond the free space.
module rx_acq_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0_i,
    input  logic [WIDTH-1:0] din0_i,
    input  logic             push1_i,
    input  logic [WIDTH-1:0] din1_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             free2_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic [1:0]       n_push;
    logic             do_pop;

    assign n_push  = {1'b0, push0_i} + {1'b0, push1_i};
    assign do_pop  = pop_i && !empty_o;
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign free2_o = (cnt_q <= (AW+1)'(DEPTH - 2));
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_q] <= din0_i;
        if (push1_i) mem_q[wr_q + AW'(1)] <= din1_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(n_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(n_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rx_acquire.sv
// rx_acquire: boxcar-decimates ADC samples during each rx window, buffers the
// words in a FIFO and streams them with the window's final word tagged last.
//   clk, rst   : clock, async active-high reset
//   enable     : acquisition enable (0->1 also clears overflow)
//   rx         : receive-window gate
//   adc_data   : signed sample, adc_valid qualifies it
//   decim      : samples per word (0 treated as 1)
//   out_if     : output stream (rx_acquire_if master)
//   rec_count  : completed windows since reset (wraps)
//   overflow   : sticky, a word was dropped on a full FIFO
//   busy       : in ACQ state
// Optional macro RX_ACQ_TIMESTAMP_EN adds out_if.out_tstamp.
module rx_acquire import rx_acquire_pkg::*; #(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned ACC_W      = ACC_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rx,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [15:0]       decim,
    rx_acquire_if.master      out_if,
    output logic [15:0]       rec_count,
    output logic              overflow,
    output logic              busy
);
    acq_state_e       state_q, state_d;
    logic             rx_d_q, en_d_q;
    logic [15:0]      decim_q, decim_d, cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             hold_v_q, hold_v_d, pend_v_q, pend_v_d;
    fifo_entry_t      hold_q, hold_d, pend_q, pend_d;
    logic [15:0]      rec_q, rec_d;
    logic             ovf_q, ovf_d;
`ifdef RX_ACQ_TIMESTAMP_EN
    logic [TSTAMP_W-1:0] ts_q, ts_d;
`endif

    logic             rise, fall;
    logic [ACC_W-1:0] sum;
    fifo_entry_t      partial, req_e, din0, din1, dout;
    logic             req_v, push0, push1, pop, full, empty, free2;

    assign rise = rx && !rx_d_q;
    assign fall = !rx && rx_d_q;

    rx_acq_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push0_i (push0),
        .din0_i  (din0),
        .push1_i (push1),
        .din1_i  (din1),
        .pop_i   (pop),
        .dout_o  (dout),
        .full_o  (full),
        .empty_o (empty),
        .free2_o (free2)
    );

    always_comb begin
        state_d  = state_q;
        decim_d  = decim_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        hold_v_d = hold_v_q;
        hold_d   = hold_q;
        pend_v_d = 1'b0;
        pend_d   = pend_q;
        rec_d    = rec_q;
        ovf_d    = ovf_q;
        sum      = acc_q + ACC_W'($signed(adc_data));
        partial  = '0;
        partial.last = 1'b1;
        partial.data = acc_q;
`ifdef RX_ACQ_TIMESTAMP_EN
        partial.tstamp = ts_q;
`endif
        req_v    = 1'b0;
        req_e    = '0;
        push0    = 1'b0;
        push1    = 1'b0;
        din0     = '0;
        din1     = '0;

        if (enable && !en_d_q) ovf_d = 1'b0;

        // Final partial deferred from a close that lacked room for two words.
        if (pend_v_q) begin
            req_v = 1'b1;
            req_e = pend_q;
        end

        case (state_q)
            IDLE: begin
                if (rise && enable) begin
                    state_d  = ACQ;
                    decim_d  = eff_decim(decim);
                    acc_d    = '0;
                    cnt_d    = '0;
                    hold_v_d = 1'b0;
                end
            end
            ACQ: begin
                if (!enable) begin
                    state_d  = IDLE;
                    acc_d    = '0;
                    cnt_d    = '0;
                    hold_v_d = 1'b0;
                end else if (fall) begin
                    state_d  = IDLE;
                    acc_d    = '0;
                    cnt_d    = '0;
                    hold_v_d = 1'b0;
                    if (cnt_q != '0) begin
                        rec_d = rec_q + 16'd1;
                        if (hold_v_q && free2) begin
                            push0 = 1'b1;
                            din0  = hold_q;
                            din0.last = 1'b0;
                            push1 = 1'b1;
                            din1  = partial;
                        end else if (hold_v_q) begin
                            req_v = 1'b1;
                            req_e = hold_q;
                            req_e.last = 1'b0;
                            pend_v_d = 1'b1;
                            pend_d   = partial;
                        end else begin
                            req_v = 1'b1;
                            req_e = partial;
                        end
                    end else if (hold_v_q) begin
                        rec_d = rec_q + 16'd1;
                        req_v = 1'b1;
                        req_e = hold_q;
                        req_e.last = 1'b1;
                    end
                end else if (adc_valid) begin
                    if (cnt_q == decim_q - 16'd1) begin
                        acc_d    = '0;
                        cnt_d    = '0;
                        hold_v_d = 1'b1;
                        hold_d   = '0;
                        hold_d.data = sum;
`ifdef RX_ACQ_TIMESTAMP_EN
                        hold_d.tstamp = ts_q;
`endif
                        if (hold_v_q) begin
                            req_v = 1'b1;
                            req_e = hold_q;
                            req_e.last = 1'b0;
                        end
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Single-word pushes share one path; a full FIFO drops the word.
        if (req_v) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                push0 = 1'b1;
                din0  = req_e;
            end
        end
    end

`ifdef RX_ACQ_TIMESTAMP_EN
    assign ts_d = rise ? '0 : ts_q + 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rx_d_q   <= 1'b0;
            en_d_q   <= 1'b0;
            decim_q  <= 16'd1;
            cnt_q    <= '0;
            acc_q    <= '0;
            hold_v_q <= 1'b0;
            hold_q   <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            rec_q    <= '0;
            ovf_q    <= 1'b0;
`ifdef RX_ACQ_TIMESTAMP_EN
            ts_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rx_d_q   <= rx;
            en_d_q   <= enable;
            decim_q  <= decim_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            hold_v_q <= hold_v_d;
            hold_q   <= hold_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            rec_q    <= rec_d;
            ovf_q    <= ovf_d;
`ifdef RX_ACQ_TIMESTAMP_EN
            ts_q     <= ts_d;
`endif
        end
    end

    assign pop              = !empty && out_if.out_ready;
    assign out_if.out_valid = !empty;
    assign out_if.out_data  = empty ? '0 : dout.data;
    assign out_if.out_last  = !empty && dout.last;
`ifdef RX_ACQ_TIMESTAMP_EN
    assign out_if.out_tstamp = empty ? '0 : dout.tstamp;
`endif
    assign rec_count = rec_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q == ACQ);
endmodule

// File: tb/tb_rx_acquire.sv
// tb_rx_acquire: scoreboard bench for rx_acquire. Each window's expected words
// are computed from its sample list (group-of-decim sums, trailing partial,
// last flag on the final word) and queued before the window is driven; a
// monitor pops and compares on every accepted output word.
module tb_rx_acquire;
    import rx_acquire_pkg::*;

    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, enable, rx, adc_valid;
    logic [15:0] adc_data, decim, rec_count;
    logic        overflow, busy;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] exp_rec = '0;
    logic        exp_ovf = 1'b0;
    int          ready_mode = 1;

    rx_acquire_if #(.ACC_W(32)) bus ();

    rx_acquire #(
        .DATA_W     (16),
        .ACC_W      (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .rx        (rx),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .decim     (decim),
        .out_if    (bus),
        .rec_count (rec_count),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    task automatic model_push(input logic [31:0] d, input logic last);
        exp_t e;
        if (exp_q.size() >= DEPTH) begin
            exp_ovf = 1'b1;
        end else begin
            e.data = d;
            e.last = last;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every accepted word must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got data %0h last %0b, expected none",
                         bus.out_data, bus.out_last);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", bus.out_data, mon_e.data);
                chk("out_last", 32'(bus.out_last), 32'(mon_e.last));
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    // abort_at < 0: normal window; otherwise enable drops after abort_at samples.
    task automatic window(input logic [15:0] dec, input logic [15:0] vals[$],
                          input bit gaps, input int abort_at);
        int unsigned d;
        int          n_used;
        logic [31:0] acc;
        int unsigned cnt;
        logic [31:0] words[$];
        d      = (dec == 16'd0) ? 1 : int'(dec);
        n_used = (abort_at >= 0 && abort_at < vals.size()) ? abort_at : vals.size();
        acc    = '0;
        cnt    = 0;
        for (int i = 0; i < n_used; i++) begin
            acc += sx(vals[i]);
            cnt++;
            if (cnt == d) begin
                words.push_back(acc);
                acc = '0;
                cnt = 0;
            end
        end
        if (abort_at >= 0) begin
            // the newest completed word is still held and gets discarded
            for (int i = 0; i + 1 < words.size(); i++) model_push(words[i], 1'b0);
        end else begin
            if (cnt > 0) words.push_back(acc);
            for (int i = 0; i < words.size(); i++)
                model_push(words[i], (i == words.size() - 1));
            if (words.size() > 0) exp_rec = exp_rec + 16'd1;
        end

        decim = dec;
        rx = 1'b1;
        adc_valid = 1'b0;
        tick();
        for (int i = 0; i < n_used; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    adc_valid = 1'b0;
                    adc_data  = 16'($urandom);
                    tick();
                end
            end
            adc_valid = 1'b1;
            adc_data  = vals[i];
            tick();
        end
        adc_valid = 1'b0;
        if (abort_at >= 0) begin
            enable = 1'b0;
            tick();
            chk("busy_after_abort", 32'(busy), 32'd0);
            rx = 1'b0;
            tick();
            enable = 1'b1;
            exp_ovf = 1'b0;
            tick();
        end else begin
            rx = 1'b0;
            adc_valid = ($urandom_range(0, 1) == 1);
            adc_data  = 16'($urandom);
            tick();
            adc_valid = 1'b0;
            tick();
        end
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("words_left_after_drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (4) tick();
    endtask

    initial begin
        logic [15:0] vals[$];
        logic [15:0] dec;
        int          ab;

        rst = 1'b1;
        enable = 1'b0;
        rx = 1'b0;
        adc_valid = 1'b0;
        adc_data = '0;
        decim = '0;
        ready_mode = 1;
        repeat (3) tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_out_data",  bus.out_data,       32'd0);
        chk("rst_rec_count", 32'(rec_count),     32'd0);
        chk("rst_overflow",  32'(overflow),      32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) tick();

        // decim 4, sixteen ones
        vals.delete();
        repeat (16) vals.push_back(16'd1);
        window(16'd4, vals, 1'b0, -1);
        drain();
        chk("rec_after_ones", 32'(rec_count), 32'(exp_rec));

        // decim 4, ten twos -> trailing partial
        vals.delete();
        repeat (10) vals.push_back(16'd2);
        window(16'd4, vals, 1'b0, -1);
        drain();
        chk("rec_after_twos", 32'(rec_count), 32'(exp_rec));

        // decim 0 acts as 1, signed samples
        vals = '{16'hFFFB, 16'd7, 16'd100};
        window(16'd0, vals, 1'b0, -1);
        drain();
        chk("rec_after_decim0", 32'(rec_count), 32'(exp_rec));

        // abort after six samples
        vals.delete();
        repeat (6) vals.push_back(16'($urandom));
        window(16'd4, vals, 1'b0, 6);
        drain();
        chk("rec_after_abort", 32'(rec_count), 32'(exp_rec));

        // window with no valid samples
        vals.delete();
        window(16'd3, vals, 1'b0, -1);
        drain();
        chk("rec_after_empty", 32'(rec_count), 32'(exp_rec));

        // overflow: consumer stalled, twenty single-sample words
        ready_mode = 0;
        tick();
        vals.delete();
        for (int i = 0; i < 20; i++) vals.push_back(16'(i + 1));
        window(16'd1, vals, 1'b0, -1);
        repeat (2) tick();
        chk("ovf_set",       32'(overflow),  32'(exp_ovf));
        chk("rec_after_ovf", 32'(rec_count), 32'(exp_rec));
        ready_mode = 1;
        drain();
        chk("ovf_sticky", 32'(overflow), 32'(exp_ovf));
        enable = 1'b0;
        tick();
        enable = 1'b1;
        exp_ovf = 1'b0;
        repeat (2) tick();
        chk("ovf_cleared", 32'(overflow), 32'(exp_ovf));

        // randomized windows with gaps, stalls and occasional aborts
        ready_mode = 2;
        for (int w = 0; w < 12; w++) begin
            vals.delete();
            repeat ($urandom_range(0, 30)) vals.push_back(16'($urandom));
            dec = 16'($urandom_range(2, 9));
            ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, vals.size())) : -1;
            window(dec, vals, 1'b1, ab);
            drain();
            chk("rec_random", 32'(rec_count), 32'(exp_rec));
            chk("ovf_random", 32'(overflow),  32'(exp_ovf));
        end

        // asynchronous reset in the middle of a window with buffered words
        ready_mode = 0;
        tick();
        decim = 16'd1;
        rx = 1'b1;
        tick();
        adc_valid = 1'b1;
        adc_data = 16'd3;
        repeat (5) tick();
        chk("busy_before_rst",  32'(busy),          32'd1);
        chk("valid_before_rst", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        exp_rec = '0;
        exp_ovf = 1'b0;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_last",  32'(bus.out_last),  32'd0);
        chk("arst_out_data",  bus.out_data,       32'd0);
        chk("arst_rec_count", 32'(rec_count),     32'(exp_rec));
        chk("arst_overflow",  32'(overflow),      32'(exp_ovf));
        chk("arst_busy",      32'(busy),          32'd0);
        adc_valid = 1'b0;
        rx = 1'b0;
        tick();
        rst = 1'b0;
        ready_mode = 1;
        repeat (4) tick();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
